// File: rtl/reset_sequencer.sv
// Staged reset-release controller. Asserts every downstream reset asynchronously,
// synchronises release of the global reset, then releases NUM_STAGES domains in
// order with a programmable gap. A software re-reset runs the same schedule and
// acknowledges completion with a single-cycle pulse.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned DELAY_W     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DELAY_W-1:0]    stage_delay,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  all_released,
  output logic                  busy
);

  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    StSync,
    StLoad,
    StWait,
    StRun,
    StSwHold
  } state_e;

  state_e                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync_n;
  logic [DELAY_W-1:0]     dly_r;
  logic [DELAY_W-1:0]     cnt;
  logic [IDX_W-1:0]       idx;
  logic                   pending;
  logic                   sw_flag;

  // Deassertion synchroniser: shifts in ones once reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

  // Sequencing FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= StSync;
      dly_r        <= '0;
      cnt          <= '0;
      idx          <= '0;
      pending      <= 1'b0;
      sw_flag      <= 1'b0;
      stage_rst_n  <= '0;
      all_released <= 1'b0;
      busy         <= 1'b1;
      sw_rst_ack   <= 1'b0;
    end else begin
      sw_rst_ack <= 1'b0;
      // Requests seen outside RUN are remembered and serviced once RUN is reached.
      if (state != StRun && sw_rst_req) begin
        pending <= 1'b1;
      end
      unique case (state)
        StSync: begin
          // Leave SYNC on the same edge that rst_sync_n rises.
          if (rst_sync_n || sync_q[SYNC_STAGES-2]) begin
            state <= StLoad;
            dly_r <= stage_delay;
            cnt   <= stage_delay;
            idx   <= '0;
          end
        end
        StLoad, StWait: begin
          state <= StWait;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            stage_rst_n[idx] <= 1'b1;
            cnt              <= dly_r;
            if (idx == LAST_IDX) begin
              state        <= StRun;
              all_released <= 1'b1;
              busy         <= 1'b0;
              if (sw_flag) begin
                sw_rst_ack <= 1'b1;
                sw_flag    <= 1'b0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        StRun: begin
          if (sw_rst_req || pending) begin
            state        <= StSwHold;
            stage_rst_n  <= '0;
            all_released <= 1'b0;
            busy         <= 1'b1;
            pending      <= 1'b0;
            sw_flag      <= 1'b1;
            dly_r        <= stage_delay;
            cnt          <= stage_delay;
          end
        end
        StSwHold: begin
          // Hold every domain in reset for dly_r+1 cycles, then reuse the release schedule.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= StWait;
            cnt   <= dly_r;
            idx   <= '0;
          end
        end
        default: begin
          state <= StSync;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: randomized delays and request timing,
// checked against a release-time schedule computed from plain arithmetic.
module tb_reset_sequencer;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] stage_delay = '0;
  logic          sw_rst_req = 1'b0;
  logic          sw_rst_ack;
  logic [NS-1:0] stage_rst_n;
  logic          all_released;
  logic          busy;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_STAGES (NS),
    .DELAY_W    (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stage_delay (stage_delay),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_ack  (sw_rst_ack),
    .stage_rst_n (stage_rst_n),
    .all_released(all_released),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Stage k is released at edge e0 + (k+1)*(d+1) and stays released.
  function automatic logic [NS-1:0] exp_stages(input int t, input int e0, input int d);
    logic [NS-1:0] r;
    for (int k = 0; k < NS; k++) r[k] = (t >= e0 + (k + 1) * (d + 1));
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    sw_rst_req = 1'b1;
    repeat (3) @(negedge clk);
    sw_rst_req = 1'b0;
    checks++; if (stage_rst_n !== '0) begin errors++;
      $display("FAIL reset stage_rst_n got %b exp %b", stage_rst_n, {NS{1'b0}}); end
    checks++; if (all_released !== 1'b0) begin errors++;
      $display("FAIL reset all_released got %b exp 0", all_released); end
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL reset busy got %b exp 1", busy); end
    checks++; if (sw_rst_ack !== 1'b0) begin errors++;
      $display("FAIL reset sw_rst_ack got %b exp 0", sw_rst_ack); end
  endtask

  // Power-on sequence; stage_delay switches to d_mid right after it was captured.
  task automatic test_power_on(input int d, input int d_mid);
    int e0, last;
    logic [NS-1:0] exp;
    reset = 1'b0;
    sw_rst_req = 1'b0;
    stage_delay = DW'(d);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    e0 = SS;
    last = e0 + NS * (d + 1);
    for (int t = 1; t <= last + 4; t++) begin
      if (t == e0 + 1) stage_delay = DW'(d_mid);
      @(negedge clk);
      exp = exp_stages(t, e0, d);
      checks++; if (stage_rst_n !== exp) begin errors++;
        $display("FAIL power_on stage_rst_n d=%0d t=%0d got %b exp %b", d, t, stage_rst_n, exp); end
      checks++; if (all_released !== (&exp)) begin errors++;
        $display("FAIL power_on all_released d=%0d t=%0d got %b exp %b", d, t, all_released, &exp); end
      checks++; if (busy !== ~(&exp)) begin errors++;
        $display("FAIL power_on busy d=%0d t=%0d got %b exp %b", d, t, busy, ~(&exp)); end
      checks++; if (sw_rst_ack !== 1'b0) begin errors++;
        $display("FAIL power_on sw_rst_ack d=%0d t=%0d got %b exp 0", d, t, sw_rst_ack); end
    end
  endtask

  // One-cycle request from RUN; t=0 is the edge that samples it.
  task automatic test_sw_rereset(input int d);
    int done;
    logic [NS-1:0] exp;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL sw_pre busy got %b exp 0", busy); end
    stage_delay = DW'(d);
    sw_rst_req = 1'b1;
    done = (d + 1) + NS * (d + 1);
    for (int t = 0; t <= done + 3; t++) begin
      @(negedge clk);
      sw_rst_req = 1'b0;
      if (t == 1) stage_delay = DW'($urandom_range(0, 15));
      exp = exp_stages(t, d + 1, d);
      checks++; if (stage_rst_n !== exp) begin errors++;
        $display("FAIL sw stage_rst_n d=%0d t=%0d got %b exp %b", d, t, stage_rst_n, exp); end
      checks++; if (busy !== ~(&exp)) begin errors++;
        $display("FAIL sw busy d=%0d t=%0d got %b exp %b", d, t, busy, ~(&exp)); end
      checks++; if (all_released !== (&exp)) begin errors++;
        $display("FAIL sw all_released d=%0d t=%0d got %b exp %b", d, t, all_released, &exp); end
      checks++; if (sw_rst_ack !== (t == done)) begin errors++;
        $display("FAIL sw sw_rst_ack d=%0d t=%0d got %b exp %b", d, t, sw_rst_ack, t == done); end
    end
  endtask

  // Two requests during power-on collapse into one re-reset right after RUN entry.
  task automatic test_double_req(input int d);
    int e0, r, e1, done, p1, p2, acks;
    logic [NS-1:0] exp;
    reset = 1'b0;
    sw_rst_req = 1'b0;
    stage_delay = DW'(d);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    e0 = SS;
    r = e0 + NS * (d + 1);
    p1 = int'($urandom_range(1, r));
    p2 = int'($urandom_range(1, r));
    if (p2 == p1) p2 = (p1 == 1) ? 2 : p1 - 1;
    e1 = r + 1 + (d + 1);
    done = e1 + NS * (d + 1);
    acks = 0;
    for (int t = 1; t <= done + 4; t++) begin
      sw_rst_req = (t == p1) || (t == p2);
      @(negedge clk);
      exp = (t <= r) ? exp_stages(t, e0, d) : exp_stages(t, e1, d);
      acks += int'(sw_rst_ack);
      checks++; if (stage_rst_n !== exp) begin errors++;
        $display("FAIL dbl stage_rst_n d=%0d p=%0d,%0d t=%0d got %b exp %b",
                 d, p1, p2, t, stage_rst_n, exp); end
      checks++; if (busy !== ~(&exp)) begin errors++;
        $display("FAIL dbl busy d=%0d t=%0d got %b exp %b", d, t, busy, ~(&exp)); end
      checks++; if (sw_rst_ack !== (t == done)) begin errors++;
        $display("FAIL dbl sw_rst_ack d=%0d t=%0d got %b exp %b", d, t, sw_rst_ack, t == done); end
    end
    sw_rst_req = 1'b0;
    checks++; if (acks !== 1) begin errors++;
      $display("FAIL dbl ack_count got %0d exp 1", acks); end
  endtask

  task automatic test_async_reset();
    logic [NS-1:0] exp;
    // Mid power-on, with a request left pending.
    reset = 1'b0;
    stage_delay = DW'(3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      sw_rst_req = (t == 4);
      @(negedge clk);
    end
    sw_rst_req = 1'b0;
    exp = exp_stages(10, SS, 3);
    checks++; if (stage_rst_n !== exp) begin errors++;
      $display("FAIL async_pre stage_rst_n got %b exp %b", stage_rst_n, exp); end
    #2 reset = 1'b0;
    #1;
    checks++; if (stage_rst_n !== '0) begin errors++;
      $display("FAIL async stage_rst_n got %b exp %b", stage_rst_n, {NS{1'b0}}); end
    checks++; if (busy !== 1'b1 || all_released !== 1'b0 || sw_rst_ack !== 1'b0) begin errors++;
      $display("FAIL async flags got busy=%b all=%b ack=%b exp 1 0 0",
               busy, all_released, sw_rst_ack); end
    @(negedge clk);
    test_power_on(3, 3);
    // In SW_HOLD with a further request pending; reset must drop both.
    stage_delay = DW'(5);
    sw_rst_req = 1'b1;
    repeat (2) @(negedge clk);
    sw_rst_req = 1'b0;
    checks++; if (stage_rst_n !== '0 || busy !== 1'b1) begin errors++;
      $display("FAIL hold_pre got stage=%b busy=%b exp 0 1", stage_rst_n, busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (stage_rst_n !== '0 || busy !== 1'b1 || all_released !== 1'b0) begin errors++;
      $display("FAIL hold_async got stage=%b busy=%b all=%b exp 0 1 0",
               stage_rst_n, busy, all_released); end
    @(negedge clk);
    test_power_on(2, 2);
  endtask

  initial begin
    #1 reset = 1'b0;
    test_reset();
    test_power_on(3, 7);
    test_sw_rereset(7);
    test_power_on(0, 0);
    test_sw_rereset(1);
    test_sw_rereset(0);
    for (int i = 0; i < 4; i++) begin
      test_power_on(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)));
      test_sw_rereset(int'($urandom_range(0, 5)));
    end
    test_double_req(3);
    test_double_req(int'($urandom_range(0, 4)));
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
